// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/interrupt sequencer for the 5-stage SimpleRISC pipeline.
// Optional saturating event counters are enabled with `define HAZARD_CNT_EN.
module pipeline_hazard_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_D,
    input  logic [REG_W-1:0] rs1_D,
    input  logic [REG_W-1:0] rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [REG_W-1:0] rd_E,
    input  logic             isLd_E,
    input  logic             isWb_E,
    input  logic             isbranch_taken_E,
    input  logic             isIret_E,
    input  logic             irq_req,
    output logic             stall_F,
    output logic             add_stall,
    output logic             flush_D,
    output logic             interrupt,
    output logic             irq_ack,
    output logic             in_isr,
    output logic [1:0]       state_dbg
`ifdef HAZARD_CNT_EN
    ,
    output logic [15:0]      ld_stall_cnt,
    output logic [15:0]      irq_cnt
`endif
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        TAKE  = 2'b10,
        ISR   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_q;
    logic             out_en;
    logic             ld_haz;
    logic             haz_eff;

    assign ld_haz = valid_D & isLd_E & isWb_E &
                    ((use_rs1_D & (rs1_D == rd_E)) | (use_rs2_D & (rs2_D == rd_E)));

    // Hazard is redundant while draining; the FSM already stalls and bubbles.
    assign haz_eff = ld_haz & (state_q != DRAIN);

    // Outputs stay quiet during reset and for the first cycle after it.
    assign out_en = ~rst & ~rst_q;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (irq_req && !isbranch_taken_E) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                // A redirect refills the pipe, so the drain restarts from the top.
                if (isbranch_taken_E) begin
                    cnt_d = CNT_W'(DRAIN_CYCLES);
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = TAKE;
                end
            end
            TAKE: begin
                state_d = ISR;
            end
            ISR: begin
                if (isIret_E) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_F   = 1'b0;
        add_stall = 1'b0;
        flush_D   = 1'b0;
        interrupt = 1'b0;
        irq_ack   = 1'b0;
        in_isr    = 1'b0;
        state_dbg = 2'b00;
        if (out_en) begin
            state_dbg = state_q;
            interrupt = (state_q == TAKE);
            irq_ack   = (state_q == TAKE);
            in_isr    = (state_q == ISR);
            if (isbranch_taken_E) begin
                flush_D = 1'b1;
            end else begin
                stall_F   = haz_eff | (state_q == DRAIN) | (state_q == TAKE);
                add_stall = haz_eff | (state_q == DRAIN);
            end
        end
    end

`ifdef HAZARD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_stall_cnt <= '0;
            irq_cnt      <= '0;
        end else begin
            if (out_en && haz_eff && !isbranch_taken_E && (ld_stall_cnt != '1)) begin
                ld_stall_cnt <= ld_stall_cnt + 16'd1;
            end
            if ((state_q == TAKE) && (irq_cnt != '1)) begin
                irq_cnt <= irq_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: hazard vector table, hand-written interrupt sequences, random run vs model.
module tb_pipeline_hazard_controller;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_D, use_rs1_D, use_rs2_D, isLd_E, isWb_E;
    logic [3:0] rs1_D, rs2_D, rd_E;
    logic       isbranch_taken_E, isIret_E, irq_req;
    logic       stall_F, add_stall, flush_D, interrupt, irq_ack, in_isr;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_controller #(.DRAIN_CYCLES(D), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_E(rd_E), .isLd_E(isLd_E),
        .isWb_E(isWb_E), .isbranch_taken_E(isbranch_taken_E), .isIret_E(isIret_E),
        .irq_req(irq_req), .stall_F(stall_F), .add_stall(add_stall), .flush_D(flush_D),
        .interrupt(interrupt), .irq_ack(irq_ack), .in_isr(in_isr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {stall_F, add_stall, flush_D, interrupt, irq_ack, in_isr, state_dbg}
    localparam logic [7:0] O_IDLE  = 8'b000_000_00;
    localparam logic [7:0] O_DRAIN = 8'b110_000_01;
    localparam logic [7:0] O_BRDR  = 8'b001_000_01;
    localparam logic [7:0] O_TAKE  = 8'b100_110_10;
    localparam logic [7:0] O_ISR   = 8'b000_001_11;

    typedef struct {
        string      name;
        logic       valid, u1, u2, ld, wb, br;
        logic [3:0] rs1, rs2, rd;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Reference model: remaining drain cycles, take pulse pending, handler active.
    int m_drain = 0;
    bit m_take = 0, m_isr = 0, m_post = 0;

    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] got;
        #1;
        got = {stall_F, add_stall, flush_D, interrupt, irq_ack, in_isr, state_dbg};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic ctl(input logic r, input logic irq, input logic br, input logic iret);
        rst = r; irq_req = irq; isbranch_taken_E = br; isIret_E = iret;
        valid_D = 0; use_rs1_D = 0; use_rs2_D = 0; isLd_E = 0; isWb_E = 0;
        rs1_D = 0; rs2_D = 0; rd_E = 0;
    endtask

    function automatic logic [7:0] model_out();
        logic ld, drn, st, ad, fl;
        logic [1:0] code;
        if (rst || m_post) return 8'h00;
        ld = valid_D && isLd_E && isWb_E &&
             ((use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E));
        drn = (m_drain > 0);
        code = m_isr ? 2'd3 : m_take ? 2'd2 : drn ? 2'd1 : 2'd0;
        if (isbranch_taken_E) begin
            st = 0; ad = 0; fl = 1;
        end else begin
            st = ld || drn || m_take; ad = ld || drn; fl = 0;
        end
        return {st, ad, fl, m_take, m_take, m_isr, code};
    endfunction

    task automatic model_step();
        m_post = rst;
        if (rst) begin
            m_drain = 0; m_take = 0; m_isr = 0;
        end else if (m_isr) begin
            if (isIret_E) m_isr = 0;
        end else if (m_take) begin
            m_take = 0; m_isr = 1;
        end else if (m_drain > 0) begin
            if (isbranch_taken_E) m_drain = D;
            else if (m_drain == 1) begin m_drain = 0; m_take = 1; end
            else m_drain--;
        end else if (irq_req && !isbranch_taken_E) begin
            m_drain = D;
        end
    endtask

    initial begin
        logic [7:0] e;
        vecs[0] = '{"haz_rs1",     1,1,0,1,1,0, 4,0,4, 3'b110};
        vecs[1] = '{"nohaz_rd5",   1,1,0,1,1,0, 4,0,5, 3'b000};
        vecs[2] = '{"haz_rs2",     1,0,1,1,1,0, 0,7,7, 3'b110};
        vecs[3] = '{"rs2_unused",  1,0,0,1,1,0, 0,7,7, 3'b000};
        vecs[4] = '{"bubble_D",    0,1,0,1,1,0, 4,0,4, 3'b000};
        vecs[5] = '{"no_wb",       1,1,0,1,0,0, 4,0,4, 3'b000};
        vecs[6] = '{"not_load",    1,1,0,0,1,0, 4,0,4, 3'b000};
        vecs[7] = '{"br_over_haz", 1,1,0,1,1,1, 4,0,4, 3'b001};
        vecs[8] = '{"br_alone",    0,0,0,0,0,1, 0,0,0, 3'b001};
        vecs[9] = '{"haz_rs2_only",1,0,1,1,1,0, 9,2,2, 3'b110};

        ctl(1, 0, 0, 0);
        @(negedge clk); chk("reset_hold", O_IDLE);
        @(negedge clk);
        ctl(0, 0, 0, 0);
        valid_D = 1; use_rs1_D = 1; rs1_D = 4; rd_E = 4; isLd_E = 1; isWb_E = 1;
        chk("post_reset_mask", O_IDLE);

        foreach (vecs[i]) begin
            @(negedge clk);
            ctl(0, 0, vecs[i].br, 0);
            valid_D = vecs[i].valid; use_rs1_D = vecs[i].u1; use_rs2_D = vecs[i].u2;
            isLd_E = vecs[i].ld; isWb_E = vecs[i].wb;
            rs1_D = vecs[i].rs1; rs2_D = vecs[i].rs2; rd_E = vecs[i].rd;
            chk(vecs[i].name, {vecs[i].exp, 5'b0});
        end

        // Interrupt entry latency
        @(negedge clk); ctl(0, 1, 0, 0); chk("irq_cycle0", O_IDLE);
        for (int c = 1; c <= D; c++) begin
            @(negedge clk); ctl(0, 0, 0, 0); chk("drain", O_DRAIN);
        end
        @(negedge clk); chk("take", O_TAKE);
        // No nesting while in the handler
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); ctl(0, 1, 0, 0); chk("isr_no_nest", O_ISR);
        end
        @(negedge clk); ctl(0, 1, 0, 1); chk("iret_cycle", O_ISR);
        @(negedge clk); ctl(0, 1, 0, 0); chk("after_iret_idle", O_IDLE);
        @(negedge clk); ctl(0, 0, 0, 0); chk("reaccept_drain1", O_DRAIN);
        @(negedge clk); ctl(0, 0, 1, 0); chk("branch_in_drain", O_BRDR);
        for (int c = 0; c < D; c++) begin
            @(negedge clk); ctl(0, 0, 0, 0); chk("drain_reload", O_DRAIN);
        end
        @(negedge clk); chk("take_delayed", O_TAKE);
        @(negedge clk); chk("isr2", O_ISR);
        @(negedge clk); ctl(0, 0, 0, 1); chk("iret2", O_ISR);
        @(negedge clk); ctl(0, 0, 1, 0); chk("idle_branch_only", O_BRDR & 8'b001_000_00);
        // Branch wins over irq in IDLE; accepted next cycle
        @(negedge clk); ctl(0, 1, 1, 0); chk("irq_vs_branch", 8'b001_000_00);
        @(negedge clk); ctl(0, 1, 0, 0); chk("irq_after_branch", O_IDLE);
        @(negedge clk); ctl(0, 0, 0, 0); chk("drain_after_br", O_DRAIN);
        // Reset mid-DRAIN
        @(negedge clk); ctl(1, 0, 0, 0); chk("rst_mid_drain", O_IDLE);
        @(negedge clk); ctl(0, 0, 0, 0); chk("rst_next_cycle", O_IDLE);
        @(negedge clk); chk("rst_stays_idle", O_IDLE);

        // Randomized run against the model, starting from reset
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = (i == 0) || ($urandom_range(0, 59) == 0);
            irq_req = ($urandom_range(0, 9) < 3);
            isbranch_taken_E = ($urandom_range(0, 9) < 2);
            isIret_E = ($urandom_range(0, 9) < 2);
            valid_D = $urandom_range(0, 1); use_rs1_D = $urandom_range(0, 1);
            use_rs2_D = $urandom_range(0, 1); isLd_E = $urandom_range(0, 1);
            isWb_E = $urandom_range(0, 1);
            rs1_D = 4'($urandom_range(0, 3)); rs2_D = 4'($urandom_range(0, 3));
            rd_E = 4'($urandom_range(0, 3));
            e = model_out();
            chk("random", e);
            @(posedge clk);
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush/interrupt sequencer for the 5-stage SimpleRISC pipeline.
- Detects load-use hazards between the instruction in Decode and a load in Execute.
- Arbitrates between branch redirects, load-use stalls and interrupt entry.
- Sequences interrupt entry with an FSM: drain, take, in-ISR, return on iret.
- Drives the decode stage's `add_stall` and `interrupt` inputs, plus fetch stall and IF/D flush.

Parameters:
- DRAIN_CYCLES, 3, bubble cycles inserted before interrupt entry; legal range ≥1.
- REG_W, 4, register-index width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- valid_D  in  1  Decode holds a real (non-bubble) instruction
- rs1_D  in  REG_W  first source index after ra/RS1 muxing
- rs2_D  in  REG_W  second source index after RD/RS2 muxing
- use_rs1_D  in  1  Decode instruction reads rs1_D
- use_rs2_D  in  1  Decode instruction reads rs2_D
- rd_E  in  REG_W  destination index in Execute
- isLd_E  in  1  Execute holds a load
- isWb_E  in  1  Execute instruction writes back
- isbranch_taken_E  in  1  branch resolved taken in Execute
- isIret_E  in  1  iret in Execute
- irq_req  in  1  level-sensitive external interrupt request
- stall_F  out  1  hold PC and the IF/D register
- add_stall  out  1  insert bubble into D/E
- flush_D  out  1  squash the IF/D register
- interrupt  out  1  one-cycle interrupt-entry pulse to decode/register file
- irq_ack  out  1  one-cycle acknowledge to the source, coincident with `interrupt`
- in_isr  out  1  handler active
- state_dbg  out  2  FSM state encoding

Behaviour:
- Reset:
  - rst is sampled on the clk edge.
  - FSM goes to IDLE and the drain counter clears.
  - All outputs are 0 while rst=1 and on the first cycle after it.
  - Reset mid-DRAIN or mid-ISR returns to IDLE with in_isr=0.
- Load-use detection (combinational), ld_haz:
  - ld_haz = valid_D & isLd_E & isWb_E & ((use_rs1_D & rs1_D==rd_E) | (use_rs2_D & rs2_D==rd_E)).
  - When ld_haz=1: stall_F=1, add_stall=1, flush_D=0.
  - Self-clears after one cycle because a bubble enters E.
- Branch:
  - isbranch_taken_E=1 forces flush_D=1, stall_F=0 and add_stall=0. Decode already squashes D/E on branch.
  - Branch has priority over ld_haz and over drain stalls.
- FSM states (state_dbg encoding):
  - IDLE (00): no stalls from the FSM.
    - irq_req & !isbranch_taken_E → DRAIN; counter loads DRAIN_CYCLES.
    - isIret_E is ignored here.
  - DRAIN (01): stall_F=1, add_stall=1, counter decrements each cycle.
    - Counter reaching 1 → TAKE.
    - isbranch_taken_E during DRAIN: stall_F=0 that cycle so PC redirects, flush_D=1, counter reloads DRAIN_CYCLES.
    - irq_req dropping during DRAIN does not abort the sequence.
  - TAKE (10): interrupt=1, irq_ack=1, stall_F=1, add_stall=0 for exactly one cycle → ISR.
  - ISR (11): in_isr=1.
    - irq_req is ignored; there is no nesting.
    - isIret_E=1 → IDLE; in_isr drops on the next cycle.
- Combination rules:
  - Outputs are the OR of ld_haz and FSM contributions, after branch override.
  - ld_haz during DRAIN is masked, since stall/bubble are already asserted.
- Counter:
  - Width is clog2(DRAIN_CYCLES+1).
  - Never wraps: decrement only while in DRAIN and count >1.
- Latency: irq_req sampled in IDLE → interrupt pulse DRAIN_CYCLES+1 cycles later, with no branch in between.
- Simultaneous events:
  - irq_req and isbranch_taken_E in IDLE: branch wins; irq is accepted the next cycle if still high.
  - isIret_E and irq_req in ISR: exit to IDLE; irq is re-accepted from IDLE on the following cycle.

Optional Feature:
HAZARD_CNT_EN
- Defined:
  - Adds outputs ld_stall_cnt[15:0] and irq_cnt[15:0].
  - ld_stall_cnt increments on each cycle with unmasked ld_haz.
  - irq_cnt increments on each TAKE cycle.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use: isLd_E=1, isWb_E=1, rd_E=4, rs1_D=4, use_rs1_D=1, valid_D=1 for one cycle → stall_F=1 and add_stall=1 that cycle only; rd_E=5 → both stay 0.
- Branch vs load-use: same hazard plus isbranch_taken_E=1 → flush_D=1, stall_F=0, add_stall=0.
- Interrupt entry, DRAIN_CYCLES=3:
  - Stimulus: irq_req=1 at cycle 0 in IDLE.
  - Cycles 1–3: stall_F=1, add_stall=1.
  - Cycle 4: interrupt=1, irq_ack=1.
  - Cycle 5 onward: in_isr=1, state_dbg=11.
- Branch during drain: isbranch_taken_E=1 in the 2nd DRAIN cycle → that cycle stall_F=0, flush_D=1; interrupt pulse delayed to 3 cycles after the branch cycle +1.
- ISR exit and no-nest:
  - Stimulus: in ISR, irq_req held 1 for 10 cycles → no second interrupt pulse.
  - Then isIret_E=1 → next cycle in_isr=0; the cycle after, state goes IDLE→DRAIN.
- Reset mid-DRAIN: rst=1 in the 2nd DRAIN cycle → next cycle state_dbg=00 and all outputs 0; with HAZARD_CNT_EN, counters read 0.
